// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the 1-1-0-1 word scanner.
// Holds controller/detector state encodings and the count-width helper.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } det_state_e;

    localparam int DEF_WORD_W = 8;
    localparam int CNT_W      = $clog2(DEF_WORD_W + 1);

    // Width needed to hold 0..w matches.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_pattern_fsm.sv
// Mealy detector for the non-overlapping serial pattern 1-1-0-1.
// Ports: CLK, RST_N (sync, active-low), CLR (sync clear), EN (step), E (bit in), Y (match).
module bit_pattern_fsm
    import seq_scan_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    input  logic CLR,
    input  logic EN,
    input  logic E,
    output logic Y
);

    det_state_e state_q;
    det_state_e state_d;

    always_comb begin
        state_d = state_q;
        if (CLR) begin
            state_d = S0;
        end else if (EN) begin
            unique case (state_q)
                S0: state_d = E ? S1 : S0;
                S1: state_d = E ? S2 : S0;
                // A third 1 does not chain into a new S1: restart cleanly.
                S2: state_d = E ? S0 : S3;
                S3: state_d = S0;
                default: state_d = S0;
            endcase
        end
    end

    assign Y = EN && !CLR && (state_q == S3) && E;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level sequencer: accepts words, scans them MSB-first through the
// 1-1-0-1 detector, returns per-word and saturating cumulative counts.
// Ports: CLK, RST_N (sync, active-low), IN_VALID/IN_READY/IN_DATA,
//        OUT_VALID/OUT_READY/OUT_COUNT/OUT_HIT, TOTAL_CNT, BUSY.
// Build option: STREAM_CONT_EN keeps detector state across word boundaries.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int TOT_W  = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    input  logic [WORD_W-1:0]           IN_DATA,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [cnt_w(WORD_W)-1:0]    OUT_COUNT,
    output logic                        OUT_HIT,
    output logic [TOT_W-1:0]            TOTAL_CNT,
    output logic                        BUSY
);

    localparam int CW = cnt_w(WORD_W);
    localparam int BW = $clog2(WORD_W);

    ctrl_state_e       state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [TOT_W-1:0]  total_q, total_d;

    logic accept;
    logic det_en;
    logic det_clr;
    logic det_y;

    assign accept = (state_q == IDLE) && IN_VALID;
    assign det_en = (state_q == SHIFT);

`ifdef STREAM_CONT_EN
    assign det_clr = 1'b0;
`else
    assign det_clr = accept;
`endif

    bit_pattern_fsm u_det (
        .CLK   (CLK),
        .RST_N (RST_N),
        .CLR   (det_clr),
        .EN    (det_en),
        .E     (shreg_q[WORD_W-1]),
        .Y     (det_y)
    );

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        total_d    = total_q;
        unique case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    shreg_d    = IN_DATA;
                    bit_cnt_d  = BW'(WORD_W - 1);
                    word_cnt_d = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (det_y) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (total_q != '1) begin
                        total_d = total_q + 1'b1;
                    end
                end
                shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                if (bit_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (OUT_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            total_q    <= total_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign BUSY      = (state_q != IDLE);
    assign OUT_COUNT = word_cnt_q;
    assign OUT_HIT   = (word_cnt_q != '0);
    assign TOTAL_CNT = total_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl (WORD_W=8, TOT_W=8).
// Scoreboard of expected per-word results, popped at each output handshake.
module tb_seq_scan_ctrl;

    localparam int WORD_W = 8;
    localparam int TOT_W  = 8;
    localparam int CW     = $clog2(WORD_W + 1);

    typedef struct {
        int cnt;
        int hit;
        int tot;
    } exp_t;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              IN_VALID;
    logic              IN_READY;
    logic [WORD_W-1:0] IN_DATA;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [CW-1:0]     OUT_COUNT;
    logic              OUT_HIT;
    logic [TOT_W-1:0]  TOTAL_CNT;
    logic              BUSY;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   m_st   = 0;
    int   m_tot  = 0;

    always #5 CLK = ~CLK;

    seq_scan_ctrl #(.WORD_W(WORD_W), .TOT_W(TOT_W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_DATA   (IN_DATA),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_COUNT (OUT_COUNT),
        .OUT_HIT   (OUT_HIT),
        .TOTAL_CNT (TOTAL_CNT),
        .BUSY      (BUSY)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: bit-serial walk of the pattern, non-overlapping.
    task automatic model_push(input logic [WORD_W-1:0] w);
        exp_t e;
        int   c;
        logic b;
        c = 0;
`ifndef STREAM_CONT_EN
        m_st = 0;
`endif
        for (int i = WORD_W - 1; i >= 0; i--) begin
            b = w[i];
            case (m_st)
                0: m_st = b ? 1 : 0;
                1: m_st = b ? 2 : 0;
                2: m_st = b ? 0 : 3;
                default: begin
                    if (b) begin
                        c++;
                        if (m_tot < 255) m_tot++;
                    end
                    m_st = 0;
                end
            endcase
        end
        e.cnt = c;
        e.hit = (c != 0) ? 1 : 0;
        e.tot = m_tot;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_word(input logic [WORD_W-1:0] w, input int hold,
                            input int full);
        int   n;
        exp_t e;
        logic [CW-1:0] cnt0;
        n = 0;
        while (!IN_READY && n < 50) begin
            tick();
            n++;
        end
        if (full) chk("in_ready_idle", int'(IN_READY), 1);
        OUT_READY = (hold > 0) ? 1'b0 : 1'b1;
        IN_DATA   = w;
        IN_VALID  = 1'b1;
        model_push(w);
        tick();
        IN_VALID = 1'b0;
        if (full) begin
            chk("busy_shift", int'(BUSY), 1);
            chk("in_ready_shift", int'(IN_READY), 0);
        end
        n = 0;
        while (!OUT_VALID && n < 50) begin
            tick();
            n++;
        end
        if (full) chk("latency", n, WORD_W);
        else chk("out_valid", int'(OUT_VALID), 1);
        cnt0 = OUT_COUNT;
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("bp_valid", int'(OUT_VALID), 1);
            chk("bp_count", int'(OUT_COUNT), int'(cnt0));
            chk("bp_in_ready", int'(IN_READY), 0);
        end
        OUT_READY = 1'b1;
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("out_count", int'(OUT_COUNT), e.cnt);
            chk("out_hit", int'(OUT_HIT), e.hit);
            chk("total_cnt", int'(TOTAL_CNT), e.tot);
        end
        tick();
        if (full) begin
            chk("idle_valid", int'(OUT_VALID), 0);
            chk("idle_ready", int'(IN_READY), 1);
        end
    endtask

    initial begin
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_DATA   = '0;
        OUT_READY = 1'b1;
        tick();
        tick();
        chk("rst_ready", int'(IN_READY), 1);
        chk("rst_valid", int'(OUT_VALID), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_count", int'(OUT_COUNT), 0);
        chk("rst_hit", int'(OUT_HIT), 0);
        chk("rst_total", int'(TOTAL_CNT), 0);
        RST_N = 1'b1;
        tick();

        run_word(8'b1101_1101, 0, 1);
        run_word(8'b0110_1000, 0, 1);
        run_word(8'b1111_0000, 0, 1);
        run_word(8'b0000_0110, 0, 1);
        run_word(8'b1000_0000, 0, 1);
        run_word(8'b1101_1101, 5, 1);

        // Reset in the middle of a word.
        IN_DATA  = 8'b1101_1101;
        IN_VALID = 1'b1;
        tick();
        IN_VALID = 1'b0;
        tick();
        tick();
        tick();
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        m_st  = 0;
        m_tot = 0;
        chk("mid_rst_ready", int'(IN_READY), 1);
        chk("mid_rst_busy", int'(BUSY), 0);
        chk("mid_rst_valid", int'(OUT_VALID), 0);
        chk("mid_rst_count", int'(OUT_COUNT), 0);
        chk("mid_rst_hit", int'(OUT_HIT), 0);
        chk("mid_rst_total", int'(TOTAL_CNT), 0);
        run_word(8'b1101_0000, 0, 1);

        for (int i = 0; i < 128; i++) begin
            run_word(8'b1101_1101, 0, 0);
        end
        chk("sat_total", int'(TOTAL_CNT), 255);
        run_word(8'b1101_1101, 0, 1);
        chk("sat_hold", int'(TOTAL_CNT), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
